// File: rtl/cpu_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// cpu_fetch_queue_if
//   Bundles the prefetch unit's memory-port handshake and its core-facing
//   instruction/redirect signals.
//
//   Memory side : mem_ce, mem_addr (to memory); mem_busy, mem_valid,
//                 mem_rdata (from memory).
//   Core side   : hold, iw_pop, redirect, redirect_pc (from core);
//                 fetch_idle, iw_valid, iw_data, iw_pc, pc_misaligned,
//                 count (to core).
//
//   modport master : the prefetch unit itself.
//   modport slave  : the environment (memory + core control).
// ---------------------------------------------------------------------------
interface cpu_fetch_queue_if #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_busy;
  logic              mem_valid;
  logic [31:0]       mem_rdata;
  logic              hold;
  logic              fetch_idle;
  logic              iw_valid;
  logic [31:0]       iw_data;
  logic [ADDR_W-1:0] iw_pc;
  logic              iw_pop;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              pc_misaligned;
  logic [CNT_W-1:0]  count;

  modport master (
    output mem_ce, mem_addr, fetch_idle, iw_valid, iw_data, iw_pc,
           pc_misaligned, count,
    input  mem_busy, mem_valid, mem_rdata, hold, iw_pop, redirect,
           redirect_pc
  );

  modport slave (
    input  mem_ce, mem_addr, fetch_idle, iw_valid, iw_data, iw_pc,
           pc_misaligned, count,
    output mem_busy, mem_valid, mem_rdata, hold, iw_pop, redirect,
           redirect_pc
  );
endinterface

// File: rtl/cpu_fetch_queue.sv
// ---------------------------------------------------------------------------
// cpu_fetch_queue
//   Instruction prefetch unit for the multi-cycle RV32 core. Keeps a
//   DEPTH-entry circular queue of {pc, iword} pairs, filled over the shared
//   memory ce/busy/valid handshake (at most one fetch outstanding) and
//   drained by control one instruction at a time via iw_pop. Yields the
//   memory port while hold is high and flushes on redirect.
//
//   Parameters:
//     ADDR_W   - fetch address width
//     DEPTH    - queue entries (1..16)
//     RESET_PC - first fetch address after reset
//
//   Ports:
//     clk      - clock
//     reset    - synchronous, active-low reset
//     bus      - cpu_fetch_queue_if.master (memory port + core interface)
//     stall_cycles, flush_count - performance counters, present only when
//                 FETCH_PERF_CNT_EN is defined
//
//   Optional build macro: FETCH_PERF_CNT_EN
//     stall_cycles : cycles with an empty queue outside HALT (saturating)
//     flush_count  : redirects that discarded queued or in-flight work
//                    (saturating)
// ---------------------------------------------------------------------------
module cpu_fetch_queue #(
  parameter int unsigned       ADDR_W   = 23,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  cpu_fetch_queue_if.master       bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [15:0]             flush_count
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WAIT_DISCARD,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  // Misaligned redirect seen while a response was still in flight: the
  // response is drained first, then the unit parks in HALT.
  logic              halt_pend_q, halt_pend_d;
  logic              mis_q, mis_d;

  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic redir_bad;
  logic can_issue;
  logic do_push;
  logic do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign redir_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  assign can_issue = !bus.hold && !bus.mem_busy;

  // Redirect outranks both queue operations; a pop on an empty queue is
  // ignored.
  assign do_push = (state_q == S_WAIT) && bus.mem_valid && !bus.redirect;
  assign do_pop  = bus.iw_pop && (count_q != '0) && !bus.redirect;

  // Queue pointers, occupancy and fetch PC.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    mis_d      = redir_bad;

    if (bus.redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
    end else begin
      if (do_push) begin
        tail_d     = ptr_inc(tail_q);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (do_pop) begin
        head_d = ptr_inc(head_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM. In IDLE there is never a fetch outstanding, so the issue rule
  // (count + outstanding < DEPTH) reduces to count < DEPTH. An aligned
  // redirect from IDLE/HALT issues straight away since the queue is being
  // emptied on the same edge.
  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;

    case (state_q)
      S_IDLE: begin
        if (bus.redirect) begin
          if (redir_bad) begin
            state_d = S_HALT;
          end else if (can_issue) begin
            state_d = S_REQ;
          end
        end else if ((count_q < CNT_W'(DEPTH)) && can_issue) begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (bus.redirect) begin
          state_d     = S_WAIT_DISCARD;
          halt_pend_d = redir_bad;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.redirect) begin
          if (bus.mem_valid) begin
            state_d = redir_bad ? S_HALT : S_IDLE;
          end else begin
            state_d     = S_WAIT_DISCARD;
            halt_pend_d = redir_bad;
          end
        end else if (bus.mem_valid) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_DISCARD: begin
        if (bus.redirect) begin
          halt_pend_d = redir_bad;
        end
        if (bus.mem_valid) begin
          if (bus.redirect ? redir_bad : halt_pend_q) begin
            state_d = S_HALT;
          end else begin
            state_d = S_IDLE;
          end
          halt_pend_d = 1'b0;
        end
      end

      S_HALT: begin
        if (bus.redirect && !redir_bad) begin
          state_d = can_issue ? S_REQ : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      halt_pend_q <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      halt_pend_q <= halt_pend_d;
      mis_q       <= mis_d;
    end
  end

  // Queue storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[tail_q] <= bus.mem_rdata;
      pc_q[tail_q]   <= fetch_pc_q;
    end
  end

  assign bus.mem_ce        = (state_q == S_REQ);
  assign bus.mem_addr      = fetch_pc_q;
  assign bus.fetch_idle    = (state_q == S_IDLE) || (state_q == S_HALT);
  assign bus.iw_valid      = (count_q != '0);
  assign bus.iw_data       = data_q[head_q];
  assign bus.iw_pc         = pc_q[head_q];
  assign bus.pc_misaligned = mis_q;
  assign bus.count         = count_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;
  logic        flush_hit;

  // A redirect loses work if the queue holds entries or a fetch is in
  // flight that would otherwise have been kept (REQ/WAIT).
  assign flush_hit = bus.redirect &&
                     ((count_q != '0) || (state_q == S_REQ) || (state_q == S_WAIT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((count_q == '0) && (state_q != S_HALT) && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (flush_hit && (flush_q != '1)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: doc/cpu_fetch_queue.md
Name: cpu_fetch_queue

Overview:
Parametrised instruction prefetch unit for the multi-cycle RV32 core. It replaces the single-word fetch path (PC → mem_addr, fetchflag → iword) with a DEPTH-entry queue of {pc, iword} pairs. The queue is filled over the shared memory ce/busy/valid handshake and drained by control one instruction at a time. It yields the memory port to load/store traffic on request and flushes on branches, jumps, ISR entry and mret.

Parameters:
ADDR_W, 23, PC/fetch address width; upper bits of mem_addr are zero-extended by the instantiating core.
DEPTH, 4, queue entries; legal range 1..16.
RESET_PC, 0, first fetch address after reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
mem_ce  out  1  one-cycle fetch request strobe to memory
mem_addr  out  ADDR_W  fetch address, valid while mem_ce=1
mem_busy  in  1  memory busy; no new request may be issued while high
mem_valid  in  1  one-cycle read data valid
mem_rdata  in  32  read data
hold  in  1  core wants the memory port for a load or store; no new fetch issued
fetch_idle  out  1  no fetch outstanding; core may use the memory port
iw_valid  out  1  queue head valid
iw_data  out  32  head instruction word
iw_pc  out  ADDR_W  head PC
iw_pop  in  1  consume head; ignored when iw_valid=0
redirect  in  1  flush and restart fetching at redirect_pc
redirect_pc  in  ADDR_W  new fetch PC
pc_misaligned  out  1  one-cycle pulse: redirect_pc[1:0]≠0
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, fetch_pc=RESET_PC, queue empty, count=0. Outputs: mem_ce=0, iw_valid=0, fetch_idle=1, pc_misaligned=0. Applied mid-transaction, reset discards any outstanding response.
- FSM states: IDLE, REQ, WAIT, WAIT_DISCARD, HALT.
- IDLE→REQ when count<DEPTH, hold=0, mem_busy=0, not HALT.
- REQ: mem_ce=1 and mem_addr=fetch_pc for exactly one cycle, then →WAIT. fetch_idle=0 in REQ, WAIT and WAIT_DISCARD.
- WAIT: on mem_valid, push {fetch_pc, mem_rdata}, fetch_pc+=4 (wraps mod 2^ADDR_W), →IDLE.
- At most one outstanding fetch. Issue rule: count + outstanding < DEPTH, so a response always has a free slot.
- Minimum latency: redirect at cycle 0, mem_ce at cycle 1, iw_valid in the cycle after mem_valid.
- Queue: circular, head/tail pointers. Push and pop in the same cycle leave count unchanged. Pop when full frees a slot the same cycle; the issue decision uses the registered count.
- Redirect has priority over push and pop:
  - Queue is emptied at the next edge (iw_valid=0 the following cycle); fetch_pc=redirect_pc.
  - In WAIT: →WAIT_DISCARD. The pending mem_valid is dropped, then →IDLE.
  - A redirect arriving in WAIT_DISCARD only updates fetch_pc.
  - Redirect and mem_valid in the same WAIT cycle: the data is dropped, →IDLE.
- Misaligned redirect (redirect_pc[1:0]≠0):
  - Queue flushed, pc_misaligned=1 for one cycle, →HALT.
  - Any outstanding response is still drained and discarded.
  - HALT exits only on an aligned redirect. A misaligned redirect in HALT pulses pc_misaligned again.
- hold: blocks only new issues. An outstanding fetch always completes. fetch_idle is combinational: state∈{IDLE,HALT}.
- DEPTH=1 degenerates to fetch-execute; no pipelining.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs stall_cycles (32) and flush_count (16), both reset to 0 and saturating.
  - stall_cycles increments each cycle iw_valid=0 and state≠HALT.
  - flush_count increments on every redirect that discards at least one queued entry or an outstanding fetch.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
1. Reset release, DEPTH=4, memory answers mem_valid 2 cycles after ce, iw_pop=0 → fetches at 0x0,0x4,0x8,0xC; count=4; no 5th mem_ce; iw_pc=0x0.
2. Queue full, iw_pop=1 for one cycle → count=3, new mem_ce with mem_addr=0x10 the following cycle, head now iw_pc=0x4.
3. Redirect to 0x100 while in WAIT for 0x8 → mem_valid data for 0x8 dropped; next mem_addr=0x100; first iw_pc=0x100; count never exceeds 1 before the refill.
4. hold=1 while a fetch is outstanding → that fetch completes, fetch_idle=1 the cycle after mem_valid, no mem_ce until hold=0.
5. Redirect to 0x102 → pc_misaligned pulses 1 cycle, iw_valid=0, no mem_ce; then redirect to 0x200 → fetching resumes at 0x200.
6. reset=0 asserted in WAIT, mem_valid arriving during reset → queue empty after reset, first mem_addr=RESET_PC, stale data never appears on iw_data.
